cdu_agc_pulser: RTL and testbench

Downstream stage of the CDU read counter: accepts single-cycle angle increment requests (1 LSB = 360°/32768) and delivers them to the AGC as rate-limited PCDU/MCDU counter pulses on the 51.2 kHz CLOCKH domain. Requests of opposite sign cancel in a signed pending accumulator. A mirror of the AGC CDU counter is kept for checking. Overflow of the pending accumulator is flagged sticky. A zero command clears the pending accumulator and the mirror.

---
 rtl/cdu_agc_pulser.sv | 101 ++++++++++
 tb/tb_cdu_agc_pulser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdu_agc_pulser.sv
// CDU angle increment pulser: accumulates signed +/-1 LSB requests and drives
// rate-limited PCDU/MCDU pulses to the AGC, keeping a mirror of the CDU counter.
module cdu_agc_pulser #(
  parameter int SPACING = 8,
  parameter int PEND_W  = 6
) (
  input  logic                     CLOCKH,
  input  logic                     rst_n,
  input  logic                     zero,
  input  logic                     inc_up,
  input  logic                     inc_dn,
  output logic                     PCDU,
  output logic                     MCDU,
  output logic [14:0]              angle,
  output logic signed [PEND_W-1:0] pending,
  output logic                     ovf,
  output logic                     busy
);

  localparam int GAP_W = $clog2(SPACING);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SPACING - 2);
  localparam logic signed [PEND_W:0] PMAX = $signed({2'b00, {(PEND_W-1){1'b1}}});
  localparam logic signed [PEND_W:0] PMIN = -PMAX;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic               can_launch;
  logic               launch_p;
  logic               launch_m;
  logic signed [PEND_W:0] sum;
  logic signed [PEND_W-1:0] pend_nxt;
  logic               ovf_set;

  // The launch decision looks only at the registered accumulator.
  assign can_launch = (state == IDLE) || ((state == GAP) && (gap_cnt == '0));
  assign launch_p   = can_launch && !pending[PEND_W-1] && (pending != '0);
  assign launch_m   = can_launch && pending[PEND_W-1];

  always_comb begin
    sum     = {pending[PEND_W-1], pending};
    ovf_set = 1'b0;
    if (launch_p) sum = sum - (PEND_W+1)'(1);
    if (launch_m) sum = sum + (PEND_W+1)'(1);
    if (inc_up && !inc_dn) sum = sum + (PEND_W+1)'(1);
    if (inc_dn && !inc_up) sum = sum - (PEND_W+1)'(1);
    // A launch always moves toward zero, so only the request can overflow.
    if (sum > PMAX) begin
      sum     = PMAX;
      ovf_set = 1'b1;
    end else if (sum < PMIN) begin
      sum     = PMIN;
      ovf_set = 1'b1;
    end
    pend_nxt = sum[PEND_W-1:0];
  end

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      PCDU    <= 1'b0;
      MCDU    <= 1'b0;
      angle   <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else if (zero) begin
      state   <= IDLE;
      gap_cnt <= '0;
      PCDU    <= 1'b0;
      MCDU    <= 1'b0;
      angle   <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (ovf_set) ovf <= 1'b1;
      PCDU <= launch_p;
      MCDU <= launch_m;
      if (launch_p)      angle <= angle + 15'd1;
      else if (launch_m) angle <= angle - 15'd1;
      unique case (state)
        IDLE: if (launch_p || launch_m) state <= PULSE;
        PULSE: begin
          state   <= GAP;
          gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt != '0)               gap_cnt <= gap_cnt - GAP_W'(1);
          else if (launch_p || launch_m)   state   <= PULSE;
          else                             state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_cdu_agc_pulser.sv
// Randomised and directed bench for cdu_agc_pulser against a time-based model:
// a pulse may launch whenever pending is nonzero and SPACING cycles have passed.
module tb_cdu_agc_pulser;

  localparam int SPACING = 8;
  localparam int PEND_W  = 6;
  localparam int PMAX    = 31;

  logic CLOCKH = 1'b0;
  logic rst_n  = 1'b0;
  logic zero   = 1'b0;
  logic inc_up = 1'b0;
  logic inc_dn = 1'b0;
  logic PCDU, MCDU, ovf, busy;
  logic [14:0] angle;
  logic signed [PEND_W-1:0] pending;

  cdu_agc_pulser #(.SPACING(SPACING), .PEND_W(PEND_W)) dut (
    .CLOCKH(CLOCKH), .rst_n(rst_n), .zero(zero), .inc_up(inc_up), .inc_dn(inc_dn),
    .PCDU(PCDU), .MCDU(MCDU), .angle(angle), .pending(pending), .ovf(ovf), .busy(busy)
  );

  always #5 CLOCKH = ~CLOCKH;

  int checks = 0;
  int failures = 0;

  // Reference model state, describing the current cycle.
  int cyc = 0;
  int m_pend, m_angle, m_last;
  bit m_p, m_m, m_ovf;

  // Observed statistics per phase.
  int pcnt, mcnt, gmin, gmax, last_pc, pmax_seen;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_angle = 0; m_last = -1000; m_p = 0; m_m = 0; m_ovf = 0;
  endtask

  task automatic model_edge(bit u, bit dn, bit z);
    int d, ls, t;
    bit launch;
    if (z) begin
      model_reset();
    end else begin
      launch = (m_pend != 0) && ((cyc + 1 - m_last) >= SPACING);
      ls = !launch ? 0 : (m_pend > 0 ? 1 : -1);
      m_p = (ls == 1);
      m_m = (ls == -1);
      if (launch) m_last = cyc + 1;
      m_angle = (m_angle + ls) & 32'h7fff;
      d = (u && !dn) ? 1 : ((dn && !u) ? -1 : 0);
      t = m_pend - ls + d;
      if (t > PMAX) begin t = PMAX; m_ovf = 1; end
      else if (t < -PMAX) begin t = -PMAX; m_ovf = 1; end
      m_pend = t;
    end
    cyc++;
  endtask

  task automatic clear_stats();
    pcnt = 0; mcnt = 0; gmin = 1000000; gmax = 0; last_pc = -1; pmax_seen = -1000;
  endtask

  task automatic compare_all();
    bit m_busy;
    m_busy = (m_pend != 0) || ((cyc - m_last) < SPACING);
    check("pcdu", int'(PCDU), int'(m_p));
    check("mcdu", int'(MCDU), int'(m_m));
    check("angle", int'(angle), m_angle);
    check("pending", int'($signed(pending)), m_pend);
    check("ovf", int'(ovf), int'(m_ovf));
    check("busy", int'(busy), int'(m_busy));
    if (PCDU) begin
      pcnt++;
      if (last_pc >= 0) begin
        if (cyc - last_pc < gmin) gmin = cyc - last_pc;
        if (cyc - last_pc > gmax) gmax = cyc - last_pc;
      end
      last_pc = cyc;
    end
    if (MCDU) mcnt++;
    if (int'($signed(pending)) > pmax_seen) pmax_seen = int'($signed(pending));
  endtask

  // Drive this cycle's inputs, advance the model, then check the next cycle.
  task automatic step(bit u, bit dn, bit z);
    inc_up = u; inc_dn = dn; zero = z;
    model_edge(u, dn, z);
    @(negedge CLOCKH);
    compare_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic wait_pcdu(string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (PCDU) begin found = 1; break; end
      step(0, 0, 0);
    end
    check(tag, int'(found), 1);
  endtask

  initial begin
    int a0, pu, pd;
    model_reset();
    clear_stats();

    // Reset held with inc_up toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCKH);
      inc_up = ~inc_up;
      check("reset_outputs", int'({PCDU, MCDU, angle, pending, ovf, busy}), 0);
    end
    @(negedge CLOCKH);
    inc_up = 0;
    rst_n  = 1;
    compare_all();
    idle(100);
    check("quiet_angle", int'(angle), 0);
    check("quiet_pulses", pcnt + mcnt, 0);

    // Single up request
    clear_stats();
    step(1, 0, 0);
    check("single_pend_c1", int'($signed(pending)), 1);
    check("single_pcdu_c1", int'(PCDU), 0);
    step(0, 0, 0);
    check("single_pcdu_c2", int'(PCDU), 1);
    check("single_angle_c2", int'(angle), 1);
    step(0, 0, 0);
    check("single_pcdu_c3", int'(PCDU), 0);
    check("single_pend_c3", int'($signed(pending)), 0);
    idle(8);
    check("single_busy_end", int'(busy), 0);
    check("single_count", pcnt, 1);

    // Burst of 10
    step(0, 0, 1);
    clear_stats();
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    idle(100);
    check("burst_pcdu_count", pcnt, 10);
    check("burst_mcdu_count", mcnt, 0);
    check("burst_gap_min", gmin, SPACING);
    check("burst_gap_max", gmax, SPACING);
    check("burst_angle", int'(angle), 10);
    check("burst_pend", int'($signed(pending)), 0);
    check("burst_pmax_le9", int'(pmax_seen <= 9), 1);
    check("burst_ovf", int'(ovf), 0);

    // Simultaneous up/down cancel
    a0 = int'(angle);
    clear_stats();
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    idle(5);
    check("cancel_pulses", pcnt + mcnt, 0);
    check("cancel_angle", int'(angle), a0);
    check("cancel_pend", int'($signed(pending)), 0);

    // +3 then -3 with the downs landing in GAP
    step(0, 0, 1);
    clear_stats();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    idle(60);
    check("gap_lead_pcdu", int'(pcnt >= 1), 1);
    check("gap_net_angle", int'(angle), (pcnt - mcnt) & 32'h7fff);
    check("gap_pend", int'($signed(pending)), 0);

    // Wrap both directions
    step(0, 0, 1);
    clear_stats();
    step(0, 1, 0);
    idle(12);
    check("wrap_down_angle", int'(angle), 32767);
    check("wrap_down_mcdu", mcnt, 1);
    step(1, 0, 0);
    idle(12);
    check("wrap_up_angle", int'(angle), 0);
    check("wrap_up_pcdu", pcnt, 1);

    // Saturation then zero during a pulse
    step(0, 0, 1);
    clear_stats();
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    check("sat_pend", int'($signed(pending)), PMAX);
    check("sat_pmax", pmax_seen, PMAX);
    check("sat_ovf", int'(ovf), 1);
    check("sat_pcdu_count", pcnt, 5);
    check("sat_gap", gmax, SPACING);
    wait_pcdu("sat_wait_pcdu");
    step(0, 0, 1);
    check("zero_pcdu", int'(PCDU), 0);
    check("zero_pend", int'($signed(pending)), 0);
    check("zero_angle", int'(angle), 0);
    check("zero_ovf", int'(ovf), 0);
    check("zero_busy", int'(busy), 0);

    // Randomised traffic with varying densities
    for (int blk = 0; blk < 8; blk++) begin
      pu = (blk % 4 == 0) ? 5 : (blk % 4 == 1) ? 15 : (blk % 4 == 2) ? 40 : 80;
      pd = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 30 : 60;
      for (int i = 0; i < 250; i++)
        step($urandom_range(0, 99) < pu, $urandom_range(0, 99) < pd,
             $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset in the middle of a pulse
    step(0, 0, 1);
    step(1, 0, 0);
    wait_pcdu("arst_wait_pcdu");
    #2 rst_n = 0;
    #1;
    check("arst_pcdu", int'(PCDU), 0);
    check("arst_angle", int'(angle), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge CLOCKH);
    rst_n = 1;
    model_reset();
    compare_all();
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
